// File: rtl/booth_pkg.sv
// booth_pkg: shared digit/state encodings and iteration count for the radix-4 Booth multiplier.
package booth_pkg;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
    // digit = {negate, magnitude}
    localparam logic [2:0] DIG_ZERO = 3'b000;
    localparam logic [2:0] DIG_P1   = 3'b001;
    localparam logic [2:0] DIG_P2   = 3'b010;
    localparam logic [2:0] DIG_M1   = 3'b101;
    localparam logic [2:0] DIG_M2   = 3'b110;
    function automatic int niter(input int width);
        return width / 2 + 1;
    endfunction
endpackage

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder: maps a {q1,q0,q-1} window to a Booth digit magnitude and sign.
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] window,
    output logic [1:0] mag,
    output logic       neg
);
    logic [2:0] dig;
    always_comb begin
        case (window)
            3'b001, 3'b010: dig = DIG_P1;
            3'b011:         dig = DIG_P2;
            3'b100:         dig = DIG_M2;
            3'b101, 3'b110: dig = DIG_M1;
            default:        dig = DIG_ZERO;
        endcase
    end
    assign mag = dig[1:0];
    assign neg = dig[2];
endmodule

// File: rtl/booth_r4_mult_seq.sv
// booth_r4_mult_seq: sequential radix-4 Booth multiplier, one partial product per clock,
// signed/unsigned per operation, start/busy/done handshake with a held result.
module booth_r4_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int NITER = niter(WIDTH);
    localparam int QW    = WIDTH + 2;
    localparam int AW    = WIDTH + 4;
    localparam int TW    = AW + QW + 1;
    localparam int CW    = $clog2(NITER);
    localparam logic [CW-1:0] LAST = CW'(NITER - 1);

    state_t               state;
    logic [QW-1:0]        m, q;
    logic                 q_1;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;
    logic [1:0]           mag;
    logic                 neg;
    logic signed [AW-1:0] m_ext, pp, acc_sum;
    logic signed [TW-1:0] sh;
    logic [QW-1:0]        a_ext, b_ext;

    booth_r4_recoder u_rec (.window({q[1:0], q_1}), .mag(mag), .neg(neg));

    always_comb begin
        a_ext   = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        b_ext   = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
        m_ext   = {{2{m[QW-1]}}, m};
        pp      = mag == 2'd2 ? m_ext <<< 1 : mag == 2'd1 ? m_ext : '0;
        acc_sum = neg ? acc - pp : acc + pp;
        sh      = $signed({acc_sum, q, q_1}) >>> 2;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            prod  <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    m     <= a_ext;
                    q     <= b_ext;
                    q_1   <= 1'b0;
                    acc   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= ST_RUN;
                end
            end else begin
                acc <= sh[TW-1 -: AW];
                q   <= sh[QW:1];
                q_1 <= sh[0];
                cnt <= cnt + 1'b1;
                // After the last shift the low 2*WIDTH bits of {acc,q} are the product
                if (cnt == LAST) begin
                    prod  <= sh[2*WIDTH:1];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// tb_booth_r4_mult_seq: scoreboard bench for 8- and 16-bit instances against an arithmetic model.
module tb_booth_r4_mult_seq;
    typedef struct {
        longint unsigned prod;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i[2], start_i[2], sm_i[2];
    logic [15:0] a_i[2], b_i[2];
    logic        busy8, done8, busy16, done16;
    logic [15:0] prod8;
    logic [31:0] prod16;
    int          cyc = 0, passed = 0, total = 0;
    exp_t        sb0[$], sb1[$];
    longint unsigned held[2];
    int          busy_run[2];

    always @(posedge clk) cyc <= cyc + 1;

    booth_r4_mult_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .signed_mode(sm_i[0]),
        .a(a_i[0][7:0]), .b(b_i[0][7:0]), .busy(busy8), .done(done8), .prod(prod8));
    booth_r4_mult_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .signed_mode(sm_i[1]),
        .a(a_i[1]), .b(b_i[1]), .busy(busy16), .done(done16), .prod(prod16));

    function automatic int wd(int u); return u != 0 ? 16 : 8; endfunction
    function automatic int nit(int u); return wd(u) / 2 + 1; endfunction
    function automatic logic bz(int u); return u != 0 ? busy16 : busy8; endfunction
    function automatic logic dn(int u); return u != 0 ? done16 : done8; endfunction
    function automatic longint unsigned pr(int u);
        return u != 0 ? longint'(prod16) : longint'(prod8);
    endfunction
    function automatic int qsize(int u); return u != 0 ? sb1.size() : sb0.size(); endfunction
    function automatic void push(int u, exp_t e);
        if (u != 0) sb1.push_back(e); else sb0.push_back(e);
    endfunction
    function automatic exp_t pop(int u);
        if (u != 0) return sb1.pop_front();
        return sb0.pop_front();
    endfunction
    function automatic void flush(int u);
        if (u != 0) sb1.delete(); else sb0.delete();
    endfunction

    // exact product of the operands interpreted per mode, truncated to 2w bits
    function automatic longint unsigned model(int w, longint unsigned a, longint unsigned b, bit s);
        longint m = longint'(1) << w;
        longint x = longint'(a) % m;
        longint y = longint'(b) % m;
        if (s && x >= m / 2) x -= m;
        if (s && y >= m / 2) y -= m;
        return longint'(x * y) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    function automatic void chk(string nm, longint unsigned act, longint unsigned req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endfunction

    function automatic void mon(int u);
        exp_t e;
        if (dn(u)) begin
            chk($sformatf("w%0d_done_expected", wd(u)), longint'(qsize(u) != 0), 1);
            if (qsize(u) != 0) begin
                e = pop(u);
                chk($sformatf("w%0d_prod", wd(u)), pr(u), e.prod);
                chk($sformatf("w%0d_done_cycle", wd(u)), longint'(cyc), longint'(e.cyc));
                chk($sformatf("w%0d_busy_len", wd(u)), longint'(busy_run[u]), longint'(nit(u)));
                held[u] = e.prod;
            end
        end else begin
            chk($sformatf("w%0d_prod_hold", wd(u)), pr(u), held[u]);
        end
        busy_run[u] = bz(u) ? busy_run[u] + 1 : 0;
    endfunction

    always @(negedge clk) for (int u = 0; u < 2; u++) mon(u);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(int u);
        int n = 0;
        while (bz(u) && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) chk($sformatf("w%0d_idle_timeout", wd(u)), longint'(bz(u)), 0);
    endtask

    task automatic go(int u, longint unsigned a, longint unsigned b, bit s);
        exp_t e;
        wait_idle(u);
        a_i[u] = 16'(a);
        b_i[u] = 16'(b);
        sm_i[u] = s;
        start_i[u] = 1'b1;
        e.prod = model(wd(u), a, b, s);
        e.cyc  = cyc + 1 + nit(u);
        push(u, e);
        tick();
        start_i[u] = 1'b0;
    endtask

    task automatic seq8();
        exp_t e;
        go(0, 255, 230, 0);
        go(0, 8'h80, 8'h80, 1);
        go(0, 8'hF9, 13, 1);
        go(0, 5, 9, 0);
        wait_idle(0);
        chk("w8_b2b_in_done_cycle", longint'(done8), 1);
        go(0, 200, 250, 0);
        // start held through a run with operands changed mid-run
        wait_idle(0);
        a_i[0] = 16'd100; b_i[0] = 16'd77; sm_i[0] = 1'b0; start_i[0] = 1'b1;
        e.prod = model(8, 100, 77, 0); e.cyc = cyc + 1 + nit(0); push(0, e);
        tick();
        tick();
        a_i[0] = 16'd1; b_i[0] = 16'd1; sm_i[0] = 1'b1;
        wait_idle(0);
        e.prod = model(8, 1, 1, 1); e.cyc = cyc + 1 + nit(0); push(0, e);
        tick();
        start_i[0] = 1'b0;
        // reset sampled on the third RUN edge aborts the operation
        go(0, 150, 100, 0);
        tick();
        tick();
        rst_i[0] = 1'b0;
        tick();
        rst_i[0] = 1'b1;
        flush(0);
        held[0] = 0;
        chk("w8_abort_busy", longint'(busy8), 0);
        chk("w8_abort_done", longint'(done8), 0);
        chk("w8_abort_prod", longint'(prod8), 0);
        // reset wins over a simultaneous start
        rst_i[0] = 1'b0; start_i[0] = 1'b1; a_i[0] = 16'd3; b_i[0] = 16'd3;
        tick();
        rst_i[0] = 1'b1; start_i[0] = 1'b0;
        tick();
        chk("w8_rst_beats_start", longint'(busy8), 0);
        go(0, 233, 111, 0);
        go(0, 255, 255, 0);
        go(0, 8'h80, 8'h7F, 1);
        go(0, 0, 8'hFF, 1);
        for (int i = 0; i < 40; i++) begin
            go(0, $urandom, $urandom, 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle(0);
    endtask

    task automatic seq16();
        go(1, 65535, 65535, 0);
        go(1, 16'h8000, 32767, 1);
        go(1, 16'h8000, 16'h8000, 1);
        for (int i = 0; i < 20; i++) begin
            go(1, $urandom, $urandom, 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle(1);
    endtask

    initial begin
        int n = 0;
        for (int u = 0; u < 2; u++) begin
            rst_i[u] = 1'b0; start_i[u] = 1'b0; sm_i[u] = 1'b0;
            a_i[u] = '0; b_i[u] = '0; held[u] = 0; busy_run[u] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_i[0] = 1'b1;
        rst_i[1] = 1'b1;
        chk("w8_rst_busy", longint'(busy8), 0);
        chk("w8_rst_done", longint'(done8), 0);
        chk("w8_rst_prod", longint'(prod8), 0);
        chk("w16_rst_busy", longint'(busy16), 0);
        chk("w16_rst_done", longint'(done16), 0);
        chk("w16_rst_prod", longint'(prod16), 0);
        fork
            seq8();
            seq16();
        join
        while (sb0.size() + sb1.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", longint'(sb0.size() + sb1.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
